// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: single write port arbiter driving one-hot row enables and data into the register array.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority with index 0 highest.
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   waddr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [(1<<AW)-1:0]   row_en,
  output logic [DW-1:0]        wr_data,
  output logic                 busy
);
  localparam int PW   = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int NROW = 1 << AW;
  logic [NREQ-1:0] w_elig, r_gnt;
  logic [NROW-1:0] r_row_en;
  logic [DW-1:0]   r_wr_data;
  logic [PW-1:0]   w_win;
  logic [AW-1:0]   w_addr;
  logic            w_found;
  // a requester granted this cycle sits out the next arbitration
  assign w_elig  = req & ~r_gnt;
  assign w_found = |w_elig;
  assign busy    = w_found;
`ifdef RR_ARB_EN
  logic [PW-1:0] r_ptr;
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_elig[(int'(r_ptr) + k) % NREQ]) w_win = PW'((int'(r_ptr) + k) % NREQ);
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) r_ptr <= '0;
    else if (w_found) r_ptr <= w_win == PW'(NREQ - 1) ? '0 : w_win + 1'b1;
`else
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_elig[k]) w_win = PW'(k);
  end
`endif
  assign w_addr = waddr[w_win*AW +: AW];
  // row 0 is hardwired zero: grant still issues but no row is enabled
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_gnt     <= '0;
      r_row_en  <= '0;
      r_wr_data <= '0;
    end else if (w_found) begin
      r_gnt     <= NREQ'(1) << w_win;
      r_row_en  <= w_addr == '0 ? '0 : NROW'(1) << w_addr;
      r_wr_data <= wdata[w_win*DW +: DW];
    end else begin
      r_gnt    <= '0;
      r_row_en <= '0;
    end
  assign gnt     = r_gnt;
  assign row_en  = r_row_en;
  assign wr_data = r_wr_data;
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Single-write-port arbiter for the register file built from rows of async-clear enable flip-flops. Up to NREQ requesters compete for the one write port. The arbiter picks one per cycle (round-robin or fixed priority) and returns a one-cycle grant. It drives the registered one-hot row-enable vector and write data into the flip-flop array.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 5, register address width; the array has 2^AW rows
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester write request, level
- waddr  in  NREQ*AW  requester i address at bits [i*AW +: AW]
- wdata  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant pulse, at most one bit set
- row_en  out  2^AW  one-hot row enable to the register array (the en pins)
- wr_data  out  DW  data to the array (the d pins)
- busy  out  1  high when any eligible request is pending this cycle (combinational)

## Operation
- Eligible set E = req & ~gnt. A requester whose gnt bit is high this cycle is masked and cannot be re-granted in the next cycle.
- Each cycle, if E is nonzero, select one winner w:
  - Round-robin mode: search starts at index ptr and wraps modulo NREQ.
  - Fixed mode: lowest index wins.
- On the next edge for winner w:
  - gnt <= 1<<w
  - wr_data <= wdata[w]
  - row_en <= decode(waddr[w]), except address 0, which gives row_en = 0 (r0 hardwired zero). gnt is still issued for address 0.
  - Round-robin mode only: ptr <= (w+1) mod NREQ.
- If E is zero: gnt <= 0, row_en <= 0, wr_data holds its previous value, ptr holds.
- Requester protocol:
  - Hold req, waddr and wdata stable until gnt is seen.
  - Drop req in the gnt cycle, or keep it high to issue a new request. A new request becomes eligible one cycle after gnt.
  - A requester that drops req before grant withdraws with no side effects.
- Two requesters with the same address in successive grants: both writes occur in grant order, and the later one wins in the array.
- State elements: ptr (ceil(log2 NREQ) bits), gnt, row_en, wr_data.

## Timing
- Reset: async clr forces gnt=0, row_en=0, wr_data=0 and ptr=0 immediately, independent of clk.
- Reset mid-operation:
  - Any in-flight grant is lost and no write is issued.
  - Requesters still holding req are re-arbitrated from ptr=0 on the first edge after clr falls.
- Latency: req sampled at edge k gives gnt and row_en at edge k+1. The array captures the data at edge k+2.
- gnt, row_en and wr_data change only on clk edges or clr.
- Throughput: one write per cycle across requesters; at most one grant per two cycles per requester.
- Grant and row_en are coincident, always in the same cycle.

## Configuration
- RR_ARB_EN defined: round-robin arbitration using ptr.
  - Starvation bound: a continuously requesting requester is granted within NREQ cycles.
- RR_ARB_EN undefined: fixed priority, index 0 highest.
  - ptr is not instantiated.
  - Starvation of higher indices is permitted.

## Test plan
- Reset and single write:
  - Assert clr, then release; verify gnt=0, row_en=0, wr_data=0.
  - req=0001, waddr0=3, wdata0=0xDEADBEEF → next cycle gnt=0001, row_en=1<<3, wr_data=0xDEADBEEF.
  - Following cycle gnt=0 and row 3 reads 0xDEADBEEF.
- Round-robin (RR_ARB_EN), req=1111 held continuously:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Without the macro: grants alternate 0001 and 0010 (requester 0 masked every other cycle); requesters 2 and 3 are never granted.
- Address 0 write: req=0100, waddr2=0 → gnt=0100, row_en=0, row 0 stays 0.
- Back-to-back same address:
  - req0 writes r7=0x11 and req1 writes r7=0x22, requested together.
  - RR from ptr=0: two grants, row 7 finally equals 0x22.
- Async reset mid-grant:
  - Raise clr between edges while gnt=0010.
  - gnt and row_en drop to 0 immediately; no row changes.
  - After clr falls with req=0010 held: grant reissued one edge later.
- Withdrawal: req=0001 for one cycle while another requester is granted, then req=0000 → requester 0 never receives a gnt pulse and no row is written.
